pulse_pattern_sequencer: RTL and testbench
==========================================

// Module: pulse_pattern_sequencer
// PURPOSE
//  Sequences the 16-bit circular shift register (circ_shift_reg_16bits) used as a pulse/gap generator.
//  - Accepts a pattern/run-length request over a valid/ready handshake.
//  - Loads the pattern into the shift register, then gates its serial output for exactly N clock cycles.
//  - Counts the emitted pulses and signals completion.
//  - Sits between a host/test controller and the shift register; the shift register itself is unchanged.
// PARAMETERS
//  WIDTH  16  pattern width; must match the shift register load_in width
//  CNT_W  16  width of the run-length and pulse counters
// PORTS
//  clock         in   1      single system clock, rising edge
//  reset_n       in   1      asynchronous, active-low reset
//  req_valid     in   1      request present
//  req_ready     out  1      block can accept a request (high only in IDLE)
//  req_pattern   in   WIDTH  pattern to load into the shift register
//  req_cycles    in   CNT_W  number of RUN cycles N (0 allowed)
//  abort         in   1      terminate the current run early
//  sr_load_in    out  WIDTH  to shift register load_in
//  sr_load       out  1      to shift register load
//  sr_shift_out  in   1      from shift register shift_out
//  pulse_out     out  1      gated pulse stream: sr_shift_out & (state==RUN)
//  busy          out  1      state != IDLE
//  done          out  1      one-cycle completion strobe
//  aborted       out  1      last run ended by abort; valid from done until next accept
//  pulse_count   out  CNT_W  ones seen on pulse_out during the last/current run
// BEHAVIOUR
//  - Reset (async, takes effect immediately):
//    - state=IDLE; req_ready=1.
//    - sr_load=0, sr_load_in=0, pulse_out=0, busy=0, done=0, aborted=0, pulse_count=0.
//    - Internal pattern and cycle registers are cleared.
//    - Reset during any state abandons the run; no done strobe is issued.
//  - FSM states: IDLE, LOAD, RUN, DONE. Outputs are decoded from the registered state.
//  - IDLE: req_ready=1.
//    - Accept occurs when req_valid & req_ready is high at a clock edge.
//    - On accept: capture req_pattern and req_cycles; clear pulse_count and aborted.
//    - If req_cycles==0 -> DONE. No sr_load pulse is issued.
//    - Otherwise -> LOAD.
//  - LOAD (exactly 1 cycle):
//    - sr_load=1, sr_load_in=captured pattern.
//    - Remaining-cycle counter is set to N; next state RUN.
//    - If abort is high during LOAD -> DONE with aborted=1. The load still occurs this cycle.
//  - RUN:
//    - pulse_out follows sr_shift_out.
//    - Each cycle: counter decrements; pulse_count increments when sr_shift_out=1.
//    - After the N-th RUN cycle -> DONE, so RUN lasts exactly N cycles.
//    - pulse_count cannot exceed N, so it never overflows CNT_W.
//  - RUN with abort high:
//    - The current cycle still counts and gates its pulse.
//    - Next state is DONE with aborted=1.
//  - DONE (exactly 1 cycle): done=1, then -> IDLE.
//    - pulse_count and aborted hold until the next accept.
//  - Latency: with accept in cycle 0, LOAD is cycle 1, RUN is cycles 2..N+1, done is high in cycle N+2.
//    - For N=0, done is high in cycle 1.
//  - Ignored inputs:
//    - req_valid outside IDLE (req_ready=0); a request held high is accepted on the first IDLE cycle.
//    - abort in IDLE or DONE.
//  - sr_load_in is driven with the captured pattern from LOAD until the next accept. It is 0 only after reset.
// TESTING
//  Bench instantiates this block together with circ_shift_reg_16bits, clock period 20 ns.
//  1. Pattern 16'h8080, N=32, accept in cycle 0
//     -> sr_load=1 in cycle 1 only, with sr_load_in=8080;
//     -> 4 pulses on pulse_out, each 8 cycles apart; done in cycle 34; pulse_count=4; aborted=0.
//  2. N=0 with any pattern -> no sr_load; done in cycle 1; pulse_count=0; busy high for 1 cycle.
//  3. Pattern 16'hFFFF, N=100, abort asserted in the 10th RUN cycle
//     -> done in the next cycle; aborted=1; pulse_count=10; pulse_out=0 thereafter.
//  4. req_valid held high through run 1 with pattern 16'h0001, N=16
//     -> req_ready=0 while busy; second request accepted in the first IDLE cycle after done; pulse_count=1.
//  5. reset_n pulsed low mid-RUN of pattern FFFF, N=64
//     -> immediately busy=0, pulse_out=0, sr_load=0, pulse_count=0, req_ready=1; no done strobe.
//  6. Pattern 0, N=16 -> pulse_out stays 0; pulse_count=0.
//     Then pattern FFFF, N=16 -> pulse_count=16.

Source files
------------

// File: rtl/pulse_pattern_sequencer.sv
// Request-driven sequencer for the 16-bit circular shift register: loads a pattern,
// gates its serial output for N cycles, counts the emitted pulses and strobes done.
module pulse_pattern_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_pattern,
    input  logic [CNT_W-1:0] req_cycles,
    input  logic             abort,
    output logic [WIDTH-1:0] sr_load_in,
    output logic             sr_load,
    input  logic             sr_shift_out,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] pulse_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] pattern_q;
    logic [CNT_W-1:0] cycles_q;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] pulse_count_q;
    logic             aborted_q;
    logic             accept;
    logic             run_last;

    assign accept   = req_valid && (state == S_IDLE);
    assign run_last = (remain_q == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (req_cycles == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: state_nxt = abort ? S_DONE : S_RUN;
            S_RUN:  state_nxt = (abort || run_last) ? S_DONE : S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q <= '0;
            cycles_q  <= '0;
        end else if (accept) begin
            pattern_q <= req_pattern;
            cycles_q  <= req_cycles;
        end
    end

    // The run counter is armed in LOAD so RUN spans exactly cycles_q cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remain_q <= '0;
        end else if (state == S_LOAD) begin
            remain_q <= cycles_q;
        end else if (state == S_RUN) begin
            remain_q <= remain_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pulse_count_q <= '0;
            aborted_q     <= 1'b0;
        end else begin
            if (accept) begin
                pulse_count_q <= '0;
                aborted_q     <= 1'b0;
            end else begin
                if ((state == S_RUN) && sr_shift_out) begin
                    pulse_count_q <= pulse_count_q + CNT_W'(1);
                end
                if (((state == S_LOAD) || (state == S_RUN)) && abort) begin
                    aborted_q <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = (state == S_IDLE);
    assign sr_load     = (state == S_LOAD);
    assign sr_load_in  = pattern_q;
    assign pulse_out   = sr_shift_out && (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign aborted     = aborted_q;
    assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_pulse_pattern_sequencer.sv
// Directed bench for pulse_pattern_sequencer with a behavioural MSB-first
// circular shift register standing in for circ_shift_reg_16bits.
module tb_pulse_pattern_sequencer;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_pattern;
    logic [15:0] req_cycles;
    logic        abort;
    logic [15:0] sr_load_in;
    logic        sr_load;
    logic        sr_shift_out;
    logic        pulse_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] pulse_count;

    logic [15:0] sr_q;
    int unsigned checks;
    int unsigned failures;

    pulse_pattern_sequencer #(.WIDTH(16), .CNT_W(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_pattern  (req_pattern),
        .req_cycles   (req_cycles),
        .abort        (abort),
        .sr_load_in   (sr_load_in),
        .sr_load      (sr_load),
        .sr_shift_out (sr_shift_out),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .pulse_count  (pulse_count)
    );

    // Shift register model: rotate left every cycle, serial output is the MSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else if (sr_load) begin
            sr_q <= sr_load_in;
        end else begin
            sr_q <= {sr_q[14:0], sr_q[15]};
        end
    end
    assign sr_shift_out = sr_q[15];

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept a request in the current cycle, then follow it through DONE.
    task automatic run_req(input string tag, input logic [15:0] pat, input logic [15:0] n,
                           output int unsigned seen);
        seen        = 0;
        req_pattern = pat;
        req_cycles  = n;
        req_valid   = 1'b1;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        if (n != 0) begin
            check_eq({tag, "_load"}, 32'(sr_load), 32'd1);
            check_eq({tag, "_load_in"}, 32'(sr_load_in), 32'(pat));
            for (int unsigned k = 0; k < n; k++) begin
                tick();
                if (pulse_out) seen++;
                if (done) check_eq({tag, "_early_done"}, 32'(done), 32'd0);
            end
            tick();
        end
        check_eq({tag, "_done"}, 32'(done), 32'd1);
    endtask

    int unsigned seen;
    int unsigned bad;

    initial begin
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_pattern = '0;
        req_cycles  = '0;
        abort       = 1'b0;
        #5;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_load", 32'(sr_load), 32'd0);
        check_eq("rst_load_in", 32'(sr_load_in), 32'd0);
        check_eq("rst_pulse", 32'(pulse_out), 32'd0);
        check_eq("rst_aborted", 32'(aborted), 32'd0);
        check_eq("rst_count", 32'(pulse_count), 32'd0);
        #10 reset_n = 1'b1;
        tick();

        // 1: 8080, N=32 -> pulses in RUN cycles 1, 9, 17, 25; done in cycle 34
        req_pattern = 16'h8080;
        req_cycles  = 16'd32;
        req_valid   = 1'b1;
        check_eq("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_eq("t1_load", 32'(sr_load), 32'd1);
        check_eq("t1_load_in", 32'(sr_load_in), 32'h8080);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_ready_busy", 32'(req_ready), 32'd0);
        bad = 0;
        for (int unsigned k = 1; k <= 32; k++) begin
            tick();
            if (pulse_out !== (((k - 1) % 8) == 0)) bad++;
            if (sr_load || done) bad++;
        end
        check_eq("t1_run_pattern", 32'(bad), 32'd0);
        tick();
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_count", 32'(pulse_count), 32'd4);
        check_eq("t1_aborted", 32'(aborted), 32'd0);
        check_eq("t1_pulse_done", 32'(pulse_out), 32'd0);
        tick();
        check_eq("t1_done_one", 32'(done), 32'd0);
        check_eq("t1_idle", 32'(busy), 32'd0);
        check_eq("t1_count_hold", 32'(pulse_count), 32'd4);

        // 2: N=0 -> no load, done in cycle 1, busy for one cycle
        req_pattern = 16'h1234;
        req_cycles  = 16'd0;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_busy", 32'(busy), 32'd1);
        check_eq("t2_load", 32'(sr_load), 32'd0);
        check_eq("t2_count", 32'(pulse_count), 32'd0);
        tick();
        check_eq("t2_idle", 32'(busy), 32'd0);
        check_eq("t2_done_one", 32'(done), 32'd0);

        // 3: FFFF, N=100, abort in RUN cycle 10
        req_pattern = 16'hFFFF;
        req_cycles  = 16'd100;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int unsigned k = 1; k <= 10; k++) tick();
        abort = 1'b1;
        check_eq("t3_pulse_abort_cycle", 32'(pulse_out), 32'd1);
        tick();
        abort = 1'b0;
        check_eq("t3_done", 32'(done), 32'd1);
        check_eq("t3_aborted", 32'(aborted), 32'd1);
        check_eq("t3_count", 32'(pulse_count), 32'd10);
        check_eq("t3_pulse_done", 32'(pulse_out), 32'd0);
        tick();
        check_eq("t3_idle", 32'(busy), 32'd0);
        check_eq("t3_pulse_idle", 32'(pulse_out), 32'd0);
        check_eq("t3_aborted_hold", 32'(aborted), 32'd1);

        // 4: req_valid held through a 0001/N=16 run; re-accept on first IDLE cycle
        req_pattern = 16'h0001;
        req_cycles  = 16'd16;
        req_valid   = 1'b1;
        tick();
        bad = 0;
        for (int unsigned k = 0; k < 17; k++) begin
            if (req_ready) bad++;
            tick();
        end
        check_eq("t4_ready_low", 32'(bad), 32'd0);
        check_eq("t4_done", 32'(done), 32'd1);
        check_eq("t4_count", 32'(pulse_count), 32'd1);
        check_eq("t4_aborted", 32'(aborted), 32'd0);
        tick();
        check_eq("t4_ready_idle", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_eq("t4_reaccept_load", 32'(sr_load), 32'd1);
        check_eq("t4_reaccept_clear", 32'(pulse_count), 32'd0);
        for (int unsigned k = 0; k < 17; k++) tick();
        check_eq("t4_done2", 32'(done), 32'd1);
        check_eq("t4_count2", 32'(pulse_count), 32'd1);
        tick();

        // 5: reset mid-RUN of FFFF, N=64
        req_pattern = 16'hFFFF;
        req_cycles  = 16'd64;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int unsigned k = 0; k < 6; k++) tick();
        check_eq("t5_pre_pulse", 32'(pulse_out), 32'd1);
        #4 reset_n = 1'b0;
        #1;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_pulse", 32'(pulse_out), 32'd0);
        check_eq("t5_load", 32'(sr_load), 32'd0);
        check_eq("t5_count", 32'(pulse_count), 32'd0);
        check_eq("t5_ready", 32'(req_ready), 32'd1);
        bad = 0;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            if (done) bad++;
        end
        #5 reset_n = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            if (done || busy) bad++;
        end
        check_eq("t5_no_done", 32'(bad), 32'd0);

        // 6: all-zero pattern yields nothing; all-ones yields one pulse per cycle
        run_req("t6a", 16'h0000, 16'd16, seen);
        check_eq("t6a_seen", 32'(seen), 32'd0);
        check_eq("t6a_count", 32'(pulse_count), 32'd0);
        tick();
        run_req("t6b", 16'hFFFF, 16'd16, seen);
        check_eq("t6b_seen", 32'(seen), 32'd16);
        check_eq("t6b_count", 32'(pulse_count), 32'd16);
        tick();

        // Abort during LOAD still loads, then finishes as aborted with no pulses
        req_pattern = 16'hFFFF;
        req_cycles  = 16'd8;
        req_valid   = 1'b1;
        tick();
        req_valid = 1'b0;
        abort     = 1'b1;
        check_eq("t7_load", 32'(sr_load), 32'd1);
        tick();
        abort = 1'b0;
        check_eq("t7_done", 32'(done), 32'd1);
        check_eq("t7_aborted", 32'(aborted), 32'd1);
        check_eq("t7_count", 32'(pulse_count), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
